// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared types and constants for the DMA receive path
package ahb3lite_pkg;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_ARMED,
      RX_UNPACK,
      RX_DONE
   } rx_state_t;

   localparam int RX_MAX_LEN = 63;

   // Number of 32-bit words needed to carry len bytes (rounds up)
   function automatic logic [4:0] rx_words_for_len(input logic [5:0] len);
      logic [6:0] w_sum;
      w_sum = {1'b0, len} + 7'd3;
      return w_sum[6:2];
   endfunction

endpackage

// File: rtl/dma_rx_word_fifo.sv
// rtl/dma_rx_word_fifo.sv - word FIFO between the DMA read master and the byte unpacker
module dma_rx_word_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          i_push,
   input  logic [31:0]   i_wdata,
   input  logic          i_pop,
   output logic [31:0]   o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [31:0] r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        w_wr_en;
   logic        w_rd_en;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then
   assign w_rd_en = i_pop && !o_empty;
   assign w_wr_en = i_push && (!o_full || w_rd_en);

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

   // Storage array; contents are don't-care until written
   always_ff @(posedge HCLK) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
      end
   end

   // Extra-MSB pointers distinguish full from empty and wrap naturally at DEPTH
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/dma_rx_byte_unpacker.sv
// rtl/dma_rx_byte_unpacker.sv - buffers DMA read words and unpacks them into a byte stream
module dma_rx_byte_unpacker
   import ahb3lite_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int LEN_W = $clog2(RX_MAX_LEN + 1)
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             i_cmd_start,
   input  logic [LEN_W-1:0] i_buffer_length,
   input  logic [31:0]      i_hrdata,
   input  logic             i_hrdata_en,
   output logic [7:0]       o_byte,
   output logic             o_byte_valid,
   input  logic             i_byte_ready,
   output logic             o_busy,
   output logic             o_rx_done,
   output logic             o_overflow,
   output logic             o_proto_err
);

   rx_state_t        r_state;
   logic [4:0]       r_exp_words;
   logic [4:0]       r_words_rcvd;
   logic [LEN_W-1:0] r_bytes_left;
   logic [31:0]      r_shreg;
   logic [1:0]       r_byte_idx;
   logic             r_overflow;
   logic             r_proto_err;
   logic             r_rx_done;

   logic             w_full;
   logic             w_empty;
   logic [AW:0]      w_fifo_count;
   logic [31:0]      w_fifo_rdata;
   logic             w_push;
   logic             w_pop;
   logic             w_capture_win;
   logic             w_word_expected;
   logic             w_drop_ovf;
   logic             w_drop_proto;
   logic             w_start_ok;
   logic             w_start_bad;
   logic             w_handshake;
   logic [LEN_W-1:0] w_bytes_next;
   logic             w_word_end;

   assign w_capture_win   = (r_state == RX_ARMED) || (r_state == RX_UNPACK);
   assign w_word_expected = (r_words_rcvd < r_exp_words);
   assign w_start_ok      = i_cmd_start && (r_state == RX_IDLE);
   assign w_start_bad     = i_cmd_start && (r_state != RX_IDLE);

   assign w_handshake  = (r_state == RX_UNPACK) && i_byte_ready;
   assign w_bytes_next = r_bytes_left - 1'b1;
   assign w_word_end   = w_handshake && (r_byte_idx == 2'd3) && (w_bytes_next != '0);

   // Refill the shift register when waiting for data, or back-to-back at the end of a word
   assign w_pop = !w_empty && ((r_state == RX_ARMED) || w_word_end);

   assign w_push       = i_hrdata_en && w_capture_win && w_word_expected && (!w_full || w_pop);
   assign w_drop_ovf   = i_hrdata_en && w_capture_win && w_word_expected && w_full && !w_pop;
   assign w_drop_proto = i_hrdata_en && (!w_capture_win || !w_word_expected);

   assign o_byte       = r_shreg[7:0];
   assign o_byte_valid = (r_state == RX_UNPACK);
   assign o_busy       = (r_state == RX_ARMED) || (r_state == RX_UNPACK);
   assign o_rx_done    = r_rx_done;
   assign o_overflow   = r_overflow;
   assign o_proto_err  = r_proto_err;

   dma_rx_word_fifo #(.DEPTH(DEPTH)) u_fifo (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .i_push  (w_push),
      .i_wdata (i_hrdata),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_fifo_count)
   );

   // Word accounting and sticky error flags; a flag set wins over a same-cycle start clear
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_exp_words  <= '0;
         r_words_rcvd <= '0;
         r_overflow   <= 1'b0;
         r_proto_err  <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_exp_words  <= rx_words_for_len(i_buffer_length);
            r_words_rcvd <= '0;
            r_overflow   <= 1'b0;
            r_proto_err  <= 1'b0;
         end else if (w_push || w_drop_ovf) begin
            r_words_rcvd <= r_words_rcvd + 5'd1;
         end
         if (w_drop_ovf) r_overflow <= 1'b1;
         if (w_drop_proto || w_start_bad) r_proto_err <= 1'b1;
      end
   end

   // Transfer FSM: fetch word, shift out bytes little-endian, finish on length or lost data
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state      <= RX_IDLE;
         r_bytes_left <= '0;
         r_shreg      <= '0;
         r_byte_idx   <= '0;
         r_rx_done    <= 1'b0;
      end else begin
         r_rx_done <= (r_state == RX_DONE);
         case (r_state)
            RX_IDLE: begin
               if (w_start_ok) begin
                  r_bytes_left <= i_buffer_length;
                  r_byte_idx   <= '0;
                  r_state      <= (i_buffer_length == '0) ? RX_DONE : RX_ARMED;
               end
            end
            RX_ARMED: begin
               if (!w_empty) begin
                  r_shreg    <= w_fifo_rdata;
                  r_byte_idx <= '0;
                  r_state    <= RX_UNPACK;
               end else if (r_overflow && !w_word_expected && (w_fifo_count == '0)) begin
                  // Dropped words mean the byte count can never be reached
                  r_state <= RX_DONE;
               end
            end
            RX_UNPACK: begin
               if (w_handshake) begin
                  r_bytes_left <= w_bytes_next;
                  if (w_bytes_next == '0) begin
                     r_state <= RX_DONE;
                  end else if (r_byte_idx == 2'd3) begin
                     r_byte_idx <= '0;
                     if (!w_empty) begin
                        r_shreg <= w_fifo_rdata;
                     end else begin
                        r_state <= RX_ARMED;
                     end
                  end else begin
                     r_shreg    <= {8'h00, r_shreg[31:8]};
                     r_byte_idx <= r_byte_idx + 2'd1;
                  end
               end
            end
            RX_DONE: begin
               r_state <= RX_IDLE;
            end
            default: begin
               r_state <= RX_IDLE;
            end
         endcase
      end
   end

endmodule
